// File: rtl/uart_rx_pkg.sv
// Shared constants and state encoding for the UART receiver.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_rx_pkg;

  localparam int UART_BITS_DEF = 8;
  localparam int SB_TICKS      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status pulses out.
interface uart_rx_if #(
  parameter int UART_BITS = uart_rx_pkg::UART_BITS_DEF
);
  logic                 i_rx;
  logic                 o_rx_done;
  logic [UART_BITS-1:0] o_rx_data;
  logic                 o_frame_err;
  logic                 o_parity_err;

  modport master (output i_rx, input o_rx_done, o_rx_data, o_frame_err, o_parity_err);
  modport slave  (input i_rx, output o_rx_done, o_rx_data, o_frame_err, o_parity_err);
endinterface

// File: rtl/uart_rx_baud.sv
// Free-running oversample tick: one-cycle o_tick every TICK_DIV clocks.
module baud_rate_gen #(
  parameter int TICK_DIV = 163
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Down-counter: terminal count at zero fires the tick and reloads.
  always_comb begin
    o_tick = (cnt_q == '0);
    cnt_d  = o_tick ? RELOAD : cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampling, LSB first, one stop bit.
// Optional even-parity bit enabled by defining UART_PARITY_EN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int TICK_DIV  = 163,
  parameter int UART_BITS = UART_BITS_DEF
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  // IDLE wait for low | START confirm at mid start bit | DATA shift bits
  // PARITY sample parity | STOP check stop bit | WAIT_HIGH hold off during break
  localparam int SW = $clog2(SB_TICKS);
  localparam int NW = (UART_BITS > 1) ? $clog2(UART_BITS) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(SB_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SB_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(UART_BITS - 1);

  logic                 tick;
  logic                 sync_q, rx_s_q;
  state_e               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [UART_BITS-1:0] b_q, b_d;
  logic [UART_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  baud_rate_gen #(.TICK_DIV(TICK_DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          s_d     = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            s_d     = '0;
            n_d     = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = UART_BITS'({rx_s_q, b_q} >> 1);
            if (n_q == N_LAST) begin
`ifdef UART_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            par_d   = rx_s_q;
            state_d = S_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            if (rx_s_q) begin
              done_d  = 1'b1;
              data_d  = b_q;
`ifdef UART_PARITY_EN
              perr_d  = (^b_q) ^ par_q;
`endif
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= bus.i_rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.o_rx_done   = done_q;
  assign bus.o_rx_data   = data_q;
  assign bus.o_frame_err = ferr_q;
`ifdef UART_PARITY_EN
  assign bus.o_parity_err = perr_q;
`else
  assign bus.o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with TICK_DIV = 4 (64 clocks per bit).
module tb_uart_rx;
  localparam int TDIV = 4;
  localparam int BIT  = 16 * TDIV;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   ferr_cnt = 0;
  int   last_done_cyc = 0;
  int   stop_cyc = 0;
  logic [7:0] data_q[$];
  logic       perr_q[$];
  logic prev_done = 1'b0, prev_ferr = 1'b0, overlap = 1'b0, long_pulse = 1'b0;

  uart_rx_if #(.UART_BITS(8)) bus ();

  uart_rx #(.TICK_DIV(TDIV), .UART_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_rx_done) begin
      done_cnt++;
      data_q.push_back(bus.o_rx_data);
      perr_q.push_back(bus.o_parity_err);
      last_done_cyc = cyc;
    end
    if (bus.o_frame_err) ferr_cnt++;
    if (bus.o_rx_done && bus.o_frame_err) overlap = 1'b1;
    if ((bus.o_rx_done && prev_done) || (bus.o_frame_err && prev_ferr)) long_pulse = 1'b1;
    prev_done = bus.o_rx_done;
    prev_ferr = bus.o_frame_err;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic p);
    return PAR_EN ? ((^d) ^ p) : 1'b0;
  endfunction

  task automatic bit_t(input logic v);
    bus.i_rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(v.data[i]);
    if (PAR_EN) bit_t(v.par);
    stop_cyc = cyc;
    bit_t(v.stop);
  endtask

  task automatic expect_rx(input string nm, input logic [7:0] exp_d, input logic exp_p);
    logic [31:0] gd;
    logic        gp;
    gd = 32'hFFFF_FFFF;
    gp = 1'bx;
    if (data_q.size() != 0) begin
      gd = {24'd0, data_q.pop_front()};
      gp = perr_q.pop_front();
    end
    chk({nm, "_data"}, gd, {24'd0, exp_d});
    chk({nm, "_perr"}, {31'd0, gp}, {31'd0, exp_p});
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic p, input logic s);
    vec_t v;
    v.data     = d;
    v.par      = p;
    v.stop     = s;
    v.exp_done = s ? 1 : 0;
    v.exp_ferr = s ? 0 : 1;
    v.exp_data = d;
    return v;
  endfunction

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   d0, f0, lat;

    vecs[0] = mk(8'h03, 1'b0, 1'b1);
    vecs[1] = mk(8'h00, 1'b0, 1'b1);
    vecs[2] = mk(8'hFF, 1'b0, 1'b1);
    vecs[3] = mk(8'h80, 1'b1, 1'b1);
    vecs[4] = mk(8'h07, 1'b0, 1'b1);
    vecs[5] = mk(8'h07, 1'b1, 1'b1);
    vecs[6] = mk(8'h55, 1'b0, 1'b0);

    bus.i_rx = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done", {31'd0, bus.o_rx_done}, 32'd0);
    chk("rst_data", {24'd0, bus.o_rx_data}, 32'd0);
    chk("rst_ferr", {31'd0, bus.o_frame_err}, 32'd0);
    chk("rst_perr", {31'd0, bus.o_parity_err}, 32'd0);
    idle(BIT);

    for (int k = 0; k < 7; k++) begin
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[k]);
      idle(2 * BIT);
      chk($sformatf("v%0d_done_cnt", k), done_cnt - d0, vecs[k].exp_done);
      chk($sformatf("v%0d_ferr_cnt", k), ferr_cnt - f0, vecs[k].exp_ferr);
      if (vecs[k].exp_done != 0) begin
        expect_rx($sformatf("v%0d", k), vecs[k].exp_data, exp_perr(vecs[k].data, vecs[k].par));
        lat = last_done_cyc - stop_cyc;
        chk($sformatf("v%0d_latency_ok", k), {31'd0, (lat >= 16 && lat <= 64)}, 32'd1);
      end
    end

    // back-to-back frames, one stop bit each
    d0 = done_cnt;
    send_frame(mk(8'hA5, 1'b0, 1'b1));
    send_frame(mk(8'h5A, 1'b0, 1'b1));
    idle(2 * BIT);
    chk("b2b_done_cnt", done_cnt - d0, 32'd2);
    expect_rx("b2b_first", 8'hA5, 1'b0);
    expect_rx("b2b_second", 8'h5A, 1'b0);

    // short low glitch must be rejected
    d0 = done_cnt;
    f0 = ferr_cnt;
    bus.i_rx = 1'b0;
    repeat (8) @(negedge clk);
    idle(3 * BIT);
    chk("glitch_done_cnt", done_cnt - d0, 32'd0);
    chk("glitch_ferr_cnt", ferr_cnt - f0, 32'd0);
    send_frame(mk(8'h3C, 1'b0, 1'b1));
    idle(2 * BIT);
    chk("after_glitch_cnt", done_cnt - d0, 32'd1);
    expect_rx("after_glitch", 8'h3C, 1'b0);

    // bad stop bit followed by a held-low break
    d0 = done_cnt;
    f0 = ferr_cnt;
    v = mk(8'h81, 1'b0, 1'b0);
    send_frame(v);
    bus.i_rx = 1'b0;
    repeat (500) @(negedge clk);
    chk("break_ferr_cnt", ferr_cnt - f0, 32'd1);
    chk("break_done_cnt", done_cnt - d0, 32'd0);
    chk("break_data_kept", {24'd0, bus.o_rx_data}, 32'h3C);
    idle(2 * BIT);
    chk("break_quiet_ferr", ferr_cnt - f0, 32'd1);
    send_frame(mk(8'h42, 1'b0, 1'b1));
    idle(2 * BIT);
    chk("after_break_cnt", done_cnt - d0, 32'd1);
    expect_rx("after_break", 8'h42, 1'b0);

    // reset in the middle of data bit 4 of 0xFF
    d0 = done_cnt;
    f0 = ferr_cnt;
    bit_t(1'b0);
    for (int i = 0; i < 4; i++) bit_t(1'b1);
    bus.i_rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (BIT / 2 - 1) @(negedge clk);
    idle(4 * BIT);
    chk("rst_mid_data", {24'd0, bus.o_rx_data}, 32'd0);
    chk("rst_mid_done_cnt", done_cnt - d0, 32'd0);
    chk("rst_mid_ferr_cnt", ferr_cnt - f0, 32'd0);
    send_frame(mk(8'h11, 1'b0, 1'b1));
    idle(2 * BIT);
    chk("after_rst_cnt", done_cnt - d0, 32'd1);
    expect_rx("after_rst", 8'h11, 1'b0);

    chk("done_ferr_exclusive", {31'd0, overlap}, 32'd0);
    chk("pulse_one_cycle", {31'd0, long_pulse}, 32'd0);
    chk("no_extra_rx", data_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
